muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS core. It is the multi-cycle counterpart to the single-cycle ALU datapath.
- Executes MULT/MULTU/DIV/DIVU into HI/LO and services MTHI/MTLO writes.
- Sits beside the ALU in EX. The controller issues an op with a one-cycle start pulse and stalls MFHI/MFLO while busy is high.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
//
// Ports:
//   clk    in   rising-edge clock
//   rstn   in   asynchronous active-low reset
//   start  in   one-cycle op request, only sampled while busy=0
//   op     in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
//   A      in   rs operand (multiplicand / dividend / MTHI-MTLO data)
//   B      in   rt operand (multiplier / divisor)
//   busy   out  multiply/divide in progress (RUN or FIN)
//   done   out  one-cycle completion pulse
//   div0   out  with done: last divide had B=0
//   hi     out  HI register
//   lo     out  LO register
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    // acc_hi/acc_lo: product shift register for multiply,
    // partial remainder / quotient-dividend shift register for divide.
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] a_raw;
    logic              is_div;
    logic              neg_res;   // negate product / quotient at the end
    logic              neg_rem;   // negate remainder (dividend was negative)
    logic              b_zero;

    // Operand conditioning at issue time; unsigned ops never see a sign.
    logic              sgn_a;
    logic              sgn_b;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;

    always_comb begin
        sgn_a = ~op[0] & A[DATA_W-1];
        sgn_b = ~op[0] & B[DATA_W-1];
        mag_a = sgn_a ? -A : A;
        mag_b = sgn_b ? -B : B;
    end

    // One iteration step for each algorithm.
    logic [DATA_W:0] add_sum;
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {DATA_W{1'b0}})};
        shifted = {acc_hi, acc_lo[DATA_W-1]};
        diff    = shifted - {1'b0, opnd};
    end

    // Sign fix-up of the raw magnitude results, applied while in FIN.
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi : acc_hi;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            state   <= S_RUN;
                            cnt     <= '0;
                            div0    <= 1'b0;
                            is_div  <= op[1];
                            a_raw   <= A;
                            b_zero  <= (B == '0);
                            neg_res <= sgn_a ^ sgn_b;
                            neg_rem <= sgn_a;
                            acc_hi  <= '0;
                            if (op[1]) begin
                                acc_lo <= mag_a;
                                opnd   <= mag_b;
                            end else begin
                                acc_lo <= mag_b;
                                opnd   <= mag_a;
                            end
                        end else if (!op[1]) begin
                            if (op[0]) begin
                                lo <= A;
                            end else begin
                                hi <= A;
                            end
                            done <= 1'b1;
                            div0 <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        // Restoring step: keep the difference only when it did not borrow.
                        if (!diff[DATA_W]) begin
                            acc_hi <= diff[DATA_W-1:0];
                        end else begin
                            acc_hi <= shifted[DATA_W-1:0];
                        end
                        acc_lo <= {acc_lo[DATA_W-2:0], ~diff[DATA_W]};
                    end else begin
                        // Shift-add step: the carry out of the add re-enters as the new MSB.
                        {acc_hi, acc_lo} <= {add_sum, acc_lo[DATA_W-1:1]};
                    end
                    if (cnt == CNT_LAST) begin
                        state <= S_FIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    if (is_div) begin
                        if (b_zero) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    div0  <= is_div & b_zero;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .div0 (div0),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mh = 0;
    logic [31:0] ml = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    task automatic push_exp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      qs;
        longint      rs;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.div0 = 1'b0;
        case (o)
            3'd0: begin
                p  = 64'(sa * sbv);
                mh = p[63:32];
                ml = p[31:0];
            end
            3'd1: begin
                p  = {32'd0, a} * {32'd0, b};
                mh = p[63:32];
                ml = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    mh = a;
                    ml = 32'hFFFF_FFFF;
                    e.div0 = 1'b1;
                end else if (o == 3'd2) begin
                    qs = sa / sbv;
                    rs = sa % sbv;
                    ml = qs[31:0];
                    mh = rs[31:0];
                end else begin
                    ml = a / b;
                    mh = a % b;
                end
            end
            3'd4: mh = a;
            3'd5: ml = a;
            default: ;
        endcase
        e.hi  = mh;
        e.lo  = ml;
        e.cyc = cyc + (o[2] ? 1 : 34);
        sb_q.push_back(e);
    endtask

    // Monitor: every done must match the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("div0", 64'(div0), 64'(e.div0));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (o != 3'd6 && o != 3'd7) push_exp(o, a, b);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d expected=0 pending", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        drive(o, a, b);
        release_start();
        if (!o[2]) chk("busy_after_start", 64'(busy), 64'd1);
        wait_idle();
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rstn  = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div0", 64'(div0), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        rstn = 1'b1;

        // Directed cases.
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        run_op(3'd2, -32'sd7, 32'd2);
        run_op(3'd3, 32'd100, 32'd7);
        run_op(3'd3, 32'd5, 32'd0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd2, 32'h8000_0000, 32'd0);

        // Back-to-back MTHI / MTLO.
        drive(3'd4, 32'h1234_5678, 32'd0);
        drive(3'd5, 32'h9ABC_DEF0, 32'd0);
        release_start();
        wait_idle();
        chk("mthi_value", 64'(hi), 64'h1234_5678);
        chk("mtlo_value", 64'(lo), 64'h9ABC_DEF0);

        // Start while busy is ignored.
        drive(3'd3, 32'd1000, 32'd33);
        release_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        A     = 32'd3;
        B     = 32'd3;
        release_start();
        wait_idle();
        repeat (40) @(negedge clk);

        // Reserved op: no done, no change.
        drive(3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        release_start();
        repeat (5) @(negedge clk);
        chk("reserved_hi", 64'(hi), 64'(mh));
        chk("reserved_lo", 64'(lo), 64'(ml));
        chk("reserved_busy", 64'(busy), 64'd0);

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb);
        end

        // Reset mid-operation: no partial write, no later done.
        run_op(3'd4, 32'h5555_AAAA, 32'd0);
        drive(3'd0, 32'd12345, 32'd678);
        release_start();
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_hi", 64'(hi), 64'd0);
        chk("midreset_lo", 64'(lo), 64'd0);
        sb_q.delete();
        mh = 0;
        ml = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (45) @(negedge clk);
        chk("post_reset_hi", 64'(hi), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        run_op(3'd3, 32'd100, 32'd7);

        chk("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
